// File: rtl/gb_clk_glitcher.sv
// DMG X1 clock driver: divided clk_sys output, GameBoy tick counter,
// multi-channel phase-shortening glitches and tick-aligned stop.
//
// state  | meaning
// IDLE   | divider frozen, clkout held, waiting for start
// RUN    | divider free-running, triggers and stop evaluated
// GLITCH | MSB toggles every cycle until the latched channel's phases are spent
module gb_clk_glitcher #(
   parameter int COUNTER_WIDTH = 25,
   parameter int CLKREG_WIDTH  = 4,
   parameter int NUM_GLITCH    = 2,
   parameter int PHASE_WIDTH   = 3
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic                                clear,
   input  logic                                stop_req,
   input  logic [1:0]                          stop_align,
   input  logic [NUM_GLITCH-1:0]               glitch_en,
   input  logic [NUM_GLITCH*COUNTER_WIDTH-1:0] glitch_tick,
   input  logic [NUM_GLITCH*PHASE_WIDTH-1:0]   glitch_phases,
   output logic                                clkout,
   output logic                                running,
   output logic                                glitch_active,
   output logic [COUNTER_WIDTH-1:0]            tick_count,
   output logic [NUM_GLITCH-1:0]               glitch_done
);

   localparam int CHW = (NUM_GLITCH > 1) ? $clog2(NUM_GLITCH) : 1;
   localparam int MSB = CLKREG_WIDTH - 1;
   localparam logic [CLKREG_WIDTH-1:0]  DIV_ONE  = CLKREG_WIDTH'(1);
   localparam logic [COUNTER_WIDTH-1:0] TICK_ONE = COUNTER_WIDTH'(1);
   localparam logic [PHASE_WIDTH-1:0]   PH_ONE   = PHASE_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, RUN, GLITCH} state_t;

   state_t                              state_q, state_d;
   logic [CLKREG_WIDTH-1:0]             div_q, div_d;
   logic [COUNTER_WIDTH-1:0]            tick_q, tick_d;
   logic [NUM_GLITCH-1:0]               done_q, done_d;
   logic [PHASE_WIDTH-1:0]              rem_q, rem_d;
   logic [CHW-1:0]                      chan_q, chan_d;
   logic [NUM_GLITCH-1:0]               sh_en_q, sh_en_d;
   logic [NUM_GLITCH*COUNTER_WIDTH-1:0] sh_tick_q, sh_tick_d;
   logic [NUM_GLITCH*PHASE_WIDTH-1:0]   sh_ph_q, sh_ph_d;

   logic                     hit;
   logic [CHW-1:0]           hit_idx;
   logic [PHASE_WIDTH-1:0]   hit_ph;
   logic [CLKREG_WIDTH-1:0]  div_inc, div_tog;
   logic [COUNTER_WIDTH-1:0] tick_inc;

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      tick_d    = tick_q;
      done_d    = done_q;
      rem_d     = rem_q;
      chan_d    = chan_q;
      sh_en_d   = sh_en_q;
      sh_tick_d = sh_tick_q;
      sh_ph_d   = sh_ph_q;
      hit       = 1'b0;
      hit_idx   = '0;
      hit_ph    = '0;
      div_inc   = div_q + DIV_ONE;
      div_tog   = {~div_q[MSB], div_q[MSB-1:0]};
      tick_inc  = tick_q + TICK_ONE;

      // Descending scan so the lowest matching channel wins.
      for (int i = NUM_GLITCH - 1; i >= 0; i--) begin
         if (sh_en_q[i] && !done_q[i] &&
             tick_q == sh_tick_q[i*COUNTER_WIDTH +: COUNTER_WIDTH]) begin
            hit     = 1'b1;
            hit_idx = CHW'(i);
            hit_ph  = sh_ph_q[i*PHASE_WIDTH +: PHASE_WIDTH];
         end
      end

      if (clear) begin
         state_d = IDLE;
         div_d   = '0;
         tick_d  = '0;
         done_d  = '0;
         rem_d   = '0;
         chan_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d   = RUN;
                  sh_en_d   = glitch_en;
                  sh_tick_d = glitch_tick;
                  sh_ph_d   = glitch_phases;
               end
            end
            RUN: begin
               if (hit) begin
                  if (hit_ph == '0) begin
                     done_d[hit_idx] = 1'b1;
                     div_d           = div_inc;
                  end else begin
                     div_d = div_tog;
                     if (hit_ph == PH_ONE) begin
                        done_d[hit_idx] = 1'b1;
                     end else begin
                        rem_d   = hit_ph - PH_ONE;
                        chan_d  = hit_idx;
                        state_d = GLITCH;
                     end
                  end
               end else begin
                  div_d = div_inc;
                  if (stop_req && div_inc[MSB] && !div_q[MSB] &&
                      tick_inc[1:0] == stop_align && tick_q[1:0] != stop_align) begin
                     state_d = IDLE;
                  end
               end
            end
            GLITCH: begin
               div_d = div_tog;
               rem_d = rem_q - PH_ONE;
               if (rem_q == PH_ONE) begin
                  done_d[chan_q] = 1'b1;
                  state_d        = RUN;
               end
            end
            default: state_d = IDLE;
         endcase

         if (state_q != IDLE && div_d[MSB] && !div_q[MSB]) begin
            tick_d = tick_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         div_q     <= '0;
         tick_q    <= '0;
         done_q    <= '0;
         rem_q     <= '0;
         chan_q    <= '0;
         sh_en_q   <= '0;
         sh_tick_q <= '0;
         sh_ph_q   <= '0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         tick_q    <= tick_d;
         done_q    <= done_d;
         rem_q     <= rem_d;
         chan_q    <= chan_d;
         sh_en_q   <= sh_en_d;
         sh_tick_q <= sh_tick_d;
         sh_ph_q   <= sh_ph_d;
      end
   end

   assign clkout        = div_q[MSB];
   assign running       = (state_q != IDLE);
   assign glitch_active = (state_q == GLITCH);
   assign tick_count    = tick_q;
   assign glitch_done   = done_q;

endmodule

// File: tb/tb_gb_clk_glitcher.sv
// Bench for gb_clk_glitcher: directed scenarios plus randomized runs against
// a cycle-level behavioural model (level, position within half-period, ticks).
module tb_gb_clk_glitcher;
   localparam int CW   = 25;
   localparam int KW   = 4;
   localparam int NG   = 2;
   localparam int PW   = 3;
   localparam int HALF = 1 << (KW - 1);

   logic           clk = 1'b0;
   logic           rst, start, clear, stop_req;
   logic [1:0]     stop_align;
   logic [NG-1:0]  glitch_en;
   logic [NG*CW-1:0] glitch_tick;
   logic [NG*PW-1:0] glitch_phases;
   logic           clkout, running, glitch_active;
   logic [CW-1:0]  tick_count;
   logic [NG-1:0]  glitch_done;

   gb_clk_glitcher #(.COUNTER_WIDTH(CW), .CLKREG_WIDTH(KW), .NUM_GLITCH(NG), .PHASE_WIDTH(PW)) dut (
      .clk(clk), .rst(rst), .start(start), .clear(clear), .stop_req(stop_req),
      .stop_align(stop_align), .glitch_en(glitch_en), .glitch_tick(glitch_tick),
      .glitch_phases(glitch_phases), .clkout(clkout), .running(running),
      .glitch_active(glitch_active), .tick_count(tick_count), .glitch_done(glitch_done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model: mode 0 idle, 1 run, 2 glitch.
   int              m_mode, m_level, m_pos, m_left, m_chan;
   longint unsigned m_tick;
   bit              m_done [NG];
   bit              m_en   [NG];
   longint unsigned m_tgt  [NG];
   int              m_ph   [NG];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_level = 0; m_pos = 0; m_left = 0; m_chan = 0; m_tick = 0;
      for (int i = 0; i < NG; i++) begin
         m_done[i] = 1'b0; m_en[i] = 1'b0; m_tgt[i] = 0; m_ph[i] = 0;
      end
   endtask

   task automatic rise_or_fall();
      m_level = 1 - m_level;
      if (m_level == 1) m_tick = (m_tick + 1) % (64'd1 << CW);
   endtask

   task automatic advance();
      m_pos = (m_pos + 1) % HALF;
      if (m_pos == 0) rise_or_fall();
   endtask

   task automatic model_edge();
      int fire;
      int old_low;
      if (clear) begin
         m_mode = 0; m_level = 0; m_pos = 0; m_tick = 0; m_left = 0; m_chan = 0;
         for (int i = 0; i < NG; i++) m_done[i] = 1'b0;
      end else if (m_mode == 0) begin
         if (start) begin
            for (int i = 0; i < NG; i++) begin
               m_en[i]  = glitch_en[i];
               m_tgt[i] = glitch_tick[i*CW +: CW];
               m_ph[i]  = int'(glitch_phases[i*PW +: PW]);
            end
            m_mode = 1;
         end
      end else if (m_mode == 2) begin
         rise_or_fall();
         m_left--;
         if (m_left == 0) begin
            m_done[m_chan] = 1'b1;
            m_mode = 1;
         end
      end else begin
         fire = -1;
         for (int i = 0; i < NG; i++)
            if (fire < 0 && m_en[i] && !m_done[i] && m_tick == m_tgt[i]) fire = i;
         if (fire >= 0) begin
            if (m_ph[fire] == 0) begin
               m_done[fire] = 1'b1;
               advance();
            end else begin
               rise_or_fall();
               if (m_ph[fire] == 1) m_done[fire] = 1'b1;
               else begin
                  m_left = m_ph[fire] - 1; m_chan = fire; m_mode = 2;
               end
            end
         end else begin
            old_low = int'(m_tick % 4);
            advance();
            if (stop_req && old_low != int'(stop_align) && int'(m_tick % 4) == int'(stop_align))
               m_mode = 0;
         end
      end
   endtask

   task automatic compare_all();
      logic [NG-1:0] dv;
      for (int i = 0; i < NG; i++) dv[i] = m_done[i];
      chk("clkout", clkout, m_level);
      chk("tick_count", tick_count, m_tick);
      chk("running", running, m_mode != 0);
      chk("glitch_active", glitch_active, m_mode == 2);
      chk("glitch_done", glitch_done, dv);
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_edge();
         #1;
         compare_all();
      end
   endtask

   task automatic run_until_tick(input int t, input int budget);
      int k;
      k = 0;
      while (tick_count != CW'(t) && k < budget) begin
         step(1);
         k++;
      end
      chk("wait_tick", tick_count, t);
   endtask

   task automatic do_clear();
      clear = 1'b1; step(1); clear = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1; step(1); start = 1'b0;
   endtask

   task automatic set_cfg(input logic [NG-1:0] en, input int t0, input int t1, input int p0, input int p1);
      glitch_en     = en;
      glitch_tick   = {CW'(t1), CW'(t0)};
      glitch_phases = {PW'(p1), PW'(p0)};
   endtask

   initial begin
      int k;
      rst = 1'b1; start = 1'b0; clear = 1'b0; stop_req = 1'b0; stop_align = 2'd0;
      set_cfg(2'b00, 0, 0, 0, 0);
      model_reset();
      #2;
      compare_all();
      #20 rst = 1'b0;

      // 1: plain clocking
      do_start();
      step(7);
      chk("s1_low_before", clkout, 0);
      step(1);
      chk("s1_rise_clk", clkout, 1);
      chk("s1_rise_tick", tick_count, 1);
      step(48);
      chk("s1_tick4", tick_count, 4);

      // 2: ch0 glitch of 2 phases at tick 5
      do_clear();
      set_cfg(2'b01, 5, 0, 2, 0);
      do_start();
      run_until_tick(5, 200);
      step(1);
      chk("s2_short_low", clkout, 0);
      chk("s2_active", glitch_active, 1);
      step(1);
      chk("s2_high_again", clkout, 1);
      chk("s2_tick6", tick_count, 6);
      chk("s2_done", glitch_done, 2'b01);
      chk("s2_inactive", glitch_active, 0);
      step(7);
      chk("s2_still_high", clkout, 1);
      step(1);
      chk("s2_next_fall", clkout, 0);

      // 3: shared tick, lowest channel wins
      do_clear();
      set_cfg(2'b11, 5, 5, 2, 2);
      do_start();
      run_until_tick(12, 300);
      chk("s3_done_ch0_only", glitch_done, 2'b01);

      // 4: zero-phase channel just marks done
      do_clear();
      set_cfg(2'b01, 3, 0, 0, 0);
      do_start();
      step(56);
      chk("s4_tick4", tick_count, 4);
      chk("s4_clk", clkout, 1);
      chk("s4_done", glitch_done, 2'b01);

      // 5: aligned stop and resume
      do_clear();
      set_cfg(2'b00, 0, 0, 0, 0);
      do_start();
      run_until_tick(9, 300);
      stop_req = 1'b1; stop_align = 2'd0;
      k = 0;
      while (running && k < 200) begin step(1); k++; end
      chk("s5_stopped", running, 0);
      chk("s5_tick12", tick_count, 12);
      chk("s5_clk_high", clkout, 1);
      stop_req = 1'b0;
      step(3);
      do_start();
      chk("s5_resumed", running, 1);
      step(7);
      chk("s5_hold_high", clkout, 1);
      step(1);
      chk("s5_fall", clkout, 0);

      // 6: async reset mid-glitch, then clear beats start
      do_clear();
      set_cfg(2'b01, 5, 0, 6, 0);
      do_start();
      run_until_tick(5, 200);
      step(3);
      chk("s6_in_glitch", glitch_active, 1);
      #3 rst = 1'b1;
      #1 model_reset();
      compare_all();
      chk("s6_rst_clk", clkout, 0);
      chk("s6_rst_done", glitch_done, 2'b00);
      #2 rst = 1'b0;
      clear = 1'b1; start = 1'b1;
      step(1);
      clear = 1'b0; start = 1'b0;
      chk("s6_clear_beats_start", running, 0);

      // Randomized runs with mid-run config changes and random stops
      for (int r = 0; r < 8; r++) begin
         do_clear();
         glitch_en     = NG'($urandom);
         glitch_tick   = {CW'($urandom_range(0, 10)), CW'($urandom_range(0, 10))};
         glitch_phases = (NG*PW)'($urandom);
         do_start();
         for (int c = 0; c < 300; c++) begin
            stop_req   = ($urandom_range(0, 15) == 0);
            stop_align = 2'($urandom);
            start      = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) begin
               glitch_en     = NG'($urandom);
               glitch_tick   = {CW'($urandom_range(0, 10)), CW'($urandom_range(0, 10))};
               glitch_phases = (NG*PW)'($urandom);
            end
            step(1);
         end
         start = 1'b0; stop_req = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/gb_clk_glitcher.md
Name: gb_clk_glitcher

Overview:
Parametrised successor of the single-shot DMG overclock generator. Drives the GameBoy oscillator input (X1) from a divided FPGA clock and counts GameBoy clock ticks (clkout rising edges). Up to NUM_GLITCH independently armed glitch windows can each replace a programmable number of clkout phases with 1-clk-cycle phases. A stop request halts clocking on a selectable tick-count alignment.

Parameters:
COUNTER_WIDTH, 25, width of GameBoy tick counter and glitch tick targets
CLKREG_WIDTH, 4, divider width; clkout half-period = 2^(CLKREG_WIDTH-1) clk cycles
NUM_GLITCH, 2, number of glitch channels
PHASE_WIDTH, 3, width of per-channel overclocked-phase count

Ports:
clk  in  1  FPGA system clock
rst  in  1  asynchronous active-high reset
start  in  1  begin clocking when IDLE; ignored otherwise
clear  in  1  synchronous: divider, tick count and done flags to 0, state IDLE; beats start
stop_req  in  1  level; request halt at alignment
stop_align  in  2  tick_count[1:0] value to halt on
glitch_en  in  NUM_GLITCH  per-channel arm
glitch_tick  in  NUM_GLITCH*COUNTER_WIDTH  per-channel trigger tick (channel i at [i*CW +: CW])
glitch_phases  in  NUM_GLITCH*PHASE_WIDTH  per-channel overclocked phase count
clkout  out  1  clock to DMG X1 (divider MSB)
running  out  1  state != IDLE
glitch_active  out  1  state == GLITCH
tick_count  out  COUNTER_WIDTH  clkout rising edges since clear/rst
glitch_done  out  NUM_GLITCH  sticky per-channel completion

Behaviour:
- rst: all outputs 0, divider 0, shadow regs 0, state IDLE. clear: same except shadow regs kept.
- Shadow: on accepted start, glitch_en/tick/phases copied into shadow regs; changes during a run have no effect.
- States IDLE, RUN, GLITCH. IDLE: divider and clkout frozen.
- IDLE + start -> RUN next cycle.
- RUN, no trigger: divider += 1 per clk (wraps); clkout = divider MSB.
- Trigger in RUN: channel i with shadow_en[i], !glitch_done[i], tick_count == shadow_tick[i]; lowest index wins. Same cycle:
  - phases==0: glitch_done[i] set, normal increment, no glitch.
  - phases==1: MSB toggled, lower bits held, glitch_done[i] set, stay RUN.
  - phases>=2: MSB toggled, lower bits held, rem = phases-1, state GLITCH, channel latched.
- GLITCH: each cycle MSB toggles, lower bits held, rem -= 1; when rem reaches 0 that cycle, glitch_done[latched] set, next state RUN. Total toggles = phases exactly. Odd count inverts phase relation.
- Losing channels on a shared tick never fire (tick moves on); glitch_done stays 0. Equality match only: a target already passed never fires.
- tick_count += 1 whenever next clkout = 1 and current clkout = 0, in RUN and GLITCH; wraps at 2^COUNTER_WIDTH.
- Stop: in RUN only (not GLITCH, not trigger cycle), if stop_req and the tick_count update in that cycle goes from low bits != stop_align to == stop_align, state IDLE next cycle; clkout held high.
- Priority: rst > clear > trigger > stop > start.
- Reset mid-glitch: immediate abort, clkout 0, no done flags.

Test Plan:
1. rst, then start at cycle 0 (CLKREG_WIDTH=4) -> clkout rises at cycle 8, tick_count=1; period 16 cycles; tick_count=4 at cycle 56.
2. ch0 en, tick=5, phases=2 -> cycle after tick_count=5: clkout low 1 cycle, high again (tick_count=6, glitch_done=01, glitch_active high 1 cycle); next fall 8 cycles later.
3. ch0 and ch1 both tick=5, phases=2 -> only ch0 fires; glitch_done=01 permanently; ch1 never glitches.
4. ch0 tick=3, phases=0 -> glitch_done[0] set at tick 3, clkout waveform identical to scenario 1.
5. stop_req=1, stop_align=0 from tick 9 -> halts when tick_count becomes 12, clkout held 1, running=0; start resumes, next fall 8 cycles later.
6. rst asserted during GLITCH of scenario 2 (phases=6) -> clkout, tick_count, glitch_done 0 asynchronously; clear with start same cycle -> stays IDLE.
